// File: rtl/multi_clk_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multi_clk_divider_pkg
//  Purpose  : Shared definitions for the multi-channel clock divider: default
//             field widths, channel packing offsets and the widths of the
//             optional pulse-limit ports.
//  Ports    : none (package)
//  Options  : MULTI_CLK_DIVIDER_PULSE_LIMIT_EN enables the pulse-limit feature
//  Revision : 1.0  initial release
// ============================================================================
package multi_clk_divider_pkg;

    localparam int DEF_CHANNELS   = 2;
    localparam int DEF_SIZE       = 8;
    localparam int DEF_LIMIT_SIZE = 16;

    // Bit offset of channel idx inside a bus of width-wide fields.
    function automatic int field_lsb(input int idx, input int width);
        return idx * width;
    endfunction

`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
    // Width of the packed limit_in bus.
    function automatic int limit_bus_width(input int channels, input int limit_size);
        return channels * limit_size;
    endfunction
`endif

endpackage : multi_clk_divider_pkg
`default_nettype wire

// File: rtl/clk_divider_channel.sv
`default_nettype none
// ============================================================================
//  Module   : clk_divider_channel
//  Purpose  : One divider channel. Counts 0..P-1, drives a registered output
//             that is high while c >= P-H and a one-cycle tick on each wrap.
//             New P/H values are held in a shadow until the next wrap, sync,
//             or while the channel is disabled/idle.
//  Ports    : clk_in, reset_in      clock, synchronous active-high reset
//             enable_in             run enable
//             load_in               capture max_in/high_in into the shadow
//             sync_in               restart counter, apply the shadow
//             max_in, high_in       period P and high time H
//             clk_out, tick_out     divided clock, wrap pulse
//             limit_in, done_out    pulse limit / done pulse (optional)
//  Options  : MULTI_CLK_DIVIDER_PULSE_LIMIT_EN adds limit_in and done_out
//  Revision : 1.0  initial release
// ============================================================================
module clk_divider_channel
    import multi_clk_divider_pkg::*;
#(
    parameter int SIZE       = DEF_SIZE
`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
   ,parameter int LIMIT_SIZE = DEF_LIMIT_SIZE
`endif
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            enable_in,
    input  logic            load_in,
    input  logic            sync_in,
    input  logic [SIZE-1:0] max_in,
    input  logic [SIZE-1:0] high_in,
`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
    input  logic [LIMIT_SIZE-1:0] limit_in,
    output logic            done_out,
`endif
    output logic            clk_out,
    output logic            tick_out
);

    localparam logic [SIZE-1:0] ONE = SIZE'(1);

    logic [SIZE-1:0] cnt;
    logic [SIZE-1:0] act_p;
    logic [SIZE-1:0] act_h;
    logic [SIZE-1:0] sh_p;
    logic [SIZE-1:0] sh_h;
    logic            clk_q;
    logic            tick_q;

    logic [SIZE-1:0] thresh;
    logic            hit;
    logic            wrap;

    // Output threshold P-H, clamped to 0 when H >= P so the subtraction
    // never underflows; H = 0 always keeps the output low.
    always_comb begin
        thresh = '0;
        if (act_h < act_p) begin
            thresh = act_p - act_h;
        end
        hit  = (act_h != '0) && (cnt >= thresh);
        wrap = (act_p != '0) && (cnt == act_p - ONE);
    end

`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
    localparam logic [LIMIT_SIZE-1:0] LIM_ONE = LIMIT_SIZE'(1);

    logic [LIMIT_SIZE-1:0] remaining;
    logic                  limited;
    logic                  stopped;
    logic                  done_q;
    logic                  rise;
    logic                  exhausted;

    assign rise      = hit && !clk_q;
    assign exhausted = limited && (remaining == '0) && !stopped;
    assign done_out  = done_q;
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cnt    <= '0;
            act_p  <= '0;
            act_h  <= '0;
            sh_p   <= '0;
            sh_h   <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
            remaining <= '0;
            limited   <= 1'b0;
            stopped   <= 1'b0;
            done_q    <= 1'b0;
`endif
        end else begin
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
            done_q <= 1'b0;
`endif
            if (sync_in) begin
                cnt   <= '0;
                act_p <= sh_p;
                act_h <= sh_h;
            end else if (!enable_in) begin
                cnt   <= '0;
                act_p <= sh_p;
                act_h <= sh_h;
`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
            end else if (stopped) begin
                cnt <= '0;
            end else if (exhausted) begin
                // Last permitted pulse has been issued: park the channel.
                cnt     <= '0;
                stopped <= 1'b1;
                done_q  <= 1'b1;
`endif
            end else if (act_p == '0) begin
                // Idle period: nothing to wrap on, so take the shadow directly.
                cnt   <= '0;
                act_p <= sh_p;
                act_h <= sh_h;
            end else begin
                clk_q  <= hit;
                tick_q <= wrap;
`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
                if (rise && limited && (remaining != '0)) begin
                    remaining <= remaining - LIM_ONE;
                end
`endif
                if (wrap) begin
                    cnt <= '0;
                    // A load landing on the wrap edge bypasses the shadow.
                    act_p <= load_in ? max_in  : sh_p;
                    act_h <= load_in ? high_in : sh_h;
                end else begin
                    cnt <= cnt + ONE;
                end
            end

            if (load_in) begin
                sh_p <= max_in;
                sh_h <= high_in;
`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
                remaining <= limit_in;
                limited   <= |limit_in;
                stopped   <= 1'b0;
`endif
            end
        end
    end

    assign clk_out  = clk_q;
    assign tick_out = tick_q;

endmodule : clk_divider_channel
`default_nettype wire

// File: rtl/multi_clk_divider.sv
`default_nettype none
// ============================================================================
//  Module   : multi_clk_divider
//  Purpose  : CHANNELS independent programmable clock dividers sharing one
//             clock, reset and sync restart. Unpacks the per-channel fields
//             and fans sync_in out to every channel.
//  Ports    : clk_in, reset_in   clock, synchronous active-high reset
//             enable_in          per-channel run enable
//             max_in, high_in    packed per-channel period / high time
//             load_in            per-channel shadow load strobe
//             sync_in            restart all channels in phase
//             clk_out, tick_out  per-channel divided clock / wrap pulse
//             limit_in, done_out per-channel pulse limit / done (optional)
//  Options  : MULTI_CLK_DIVIDER_PULSE_LIMIT_EN adds limit_in and done_out
//  Revision : 1.0  initial release
// ============================================================================
module multi_clk_divider
    import multi_clk_divider_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int SIZE       = DEF_SIZE,
    parameter int LIMIT_SIZE = DEF_LIMIT_SIZE
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [CHANNELS-1:0]      enable_in,
    input  logic [CHANNELS*SIZE-1:0] max_in,
    input  logic [CHANNELS*SIZE-1:0] high_in,
    input  logic [CHANNELS-1:0]      load_in,
    input  logic                     sync_in,
`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
    input  logic [limit_bus_width(CHANNELS, LIMIT_SIZE)-1:0] limit_in,
`endif
    output logic [CHANNELS-1:0]      clk_out,
    output logic [CHANNELS-1:0]      tick_out
`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
   ,output logic [CHANNELS-1:0]      done_out
`endif
);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        clk_divider_channel #(
            .SIZE       (SIZE)
`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
           ,.LIMIT_SIZE (LIMIT_SIZE)
`endif
        ) u_channel (
            .clk_in    (clk_in),
            .reset_in  (reset_in),
            .enable_in (enable_in[n]),
            .load_in   (load_in[n]),
            .sync_in   (sync_in),
            .max_in    (max_in[field_lsb(n, SIZE) +: SIZE]),
            .high_in   (high_in[field_lsb(n, SIZE) +: SIZE]),
`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
            .limit_in  (limit_in[field_lsb(n, LIMIT_SIZE) +: LIMIT_SIZE]),
            .done_out  (done_out[n]),
`endif
            .clk_out   (clk_out[n]),
            .tick_out  (tick_out[n])
        );
    end

`ifndef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
    // LIMIT_SIZE only shapes the limit port, which this build leaves out.
    if (LIMIT_SIZE < 0) begin : g_limit_size_unused
    end
`endif

endmodule : multi_clk_divider
`default_nettype wire

// File: tb/tb_multi_clk_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_clk_divider
//  Purpose  : Directed self-checking bench for multi_clk_divider (2 channels,
//             8-bit fields) with hand-computed expected outputs.
//  Options  : MULTI_CLK_DIVIDER_PULSE_LIMIT_EN adds the pulse-limit test
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_clk_divider;

    localparam int CH = 2;
    localparam int SZ = 8;
    localparam int LS = 16;

    logic             clk;
    logic             rst;
    logic [CH-1:0]    enable_in;
    logic [CH*SZ-1:0] max_in;
    logic [CH*SZ-1:0] high_in;
    logic [CH-1:0]    load_in;
    logic             sync_in;
    logic [CH-1:0]    clk_out;
    logic [CH-1:0]    tick_out;
`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
    logic [CH*LS-1:0] limit_in;
    logic [CH-1:0]    done_out;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    multi_clk_divider #(
        .CHANNELS   (CH),
        .SIZE       (SZ),
        .LIMIT_SIZE (LS)
    ) dut (
        .clk_in    (clk),
        .reset_in  (rst),
        .enable_in (enable_in),
        .max_in    (max_in),
        .high_in   (high_in),
        .load_in   (load_in),
        .sync_in   (sync_in),
`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
        .limit_in  (limit_in),
        .done_out  (done_out),
`endif
        .clk_out   (clk_out),
        .tick_out  (tick_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int ch, input logic [7:0] p, input logic [7:0] h);
        max_in[ch*SZ +: SZ]  = p;
        high_in[ch*SZ +: SZ] = h;
    endtask

    // Load the channels in mask while disabled, then let the shadow settle.
    task automatic load_idle(input logic [CH-1:0] mask);
        load_in = mask;
        step();
        load_in = '0;
        step();
    endtask

    initial begin
        logic e;
        rst       = 1'b1;
        enable_in = '0;
        max_in    = '0;
        high_in   = '0;
        load_in   = '0;
        sync_in   = 1'b0;
`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
        limit_in  = '0;
`endif
        step();
        step();
        check("rst_clk", 32'(clk_out), 32'h0);
        check("rst_tick", 32'(tick_out), 32'h0);
        rst = 1'b0;
        enable_in = 2'b11;
        step();
        check("idle_clk", 32'(clk_out), 32'h0);
        check("idle_tick", 32'(tick_out), 32'h0);
        enable_in = '0;
        step();

        // ch0 P=100 H=1: one-cycle pulse on every 100th enabled edge.
        set_cfg(0, 8'd100, 8'd1);
        load_idle(2'b01);
        enable_in = 2'b01;
        for (int k = 1; k <= 201; k++) begin
            step();
            e = (k % 100 == 0);
            check("p100_clk", 32'(clk_out[0]), 32'(e));
            check("p100_tick", 32'(tick_out[0]), 32'(e));
        end
        enable_in = '0;
        step();
        check("dis_clk", 32'(clk_out[0]), 32'h0);

        // ch1 P=10 H=5: 5 low / 5 high, tick on the last high cycle.
        set_cfg(1, 8'd10, 8'd5);
        load_idle(2'b10);
        enable_in = 2'b10;
        for (int k = 1; k <= 30; k++) begin
            step();
            check("p10h5_clk", 32'(clk_out[1]), 32'(((k - 1) % 10) >= 5));
            check("p10h5_tick", 32'(tick_out[1]), 32'(((k - 1) % 10) == 9));
        end
        enable_in = '0;
        step();

        // ch0 P=10, load P=4 while c=3: new period only after the wrap.
        set_cfg(0, 8'd10, 8'd1);
        load_idle(2'b01);
        enable_in = 2'b01;
        for (int k = 1; k <= 22; k++) begin
            if (k == 4) begin
                set_cfg(0, 8'd4, 8'd1);
                load_in = 2'b01;
            end
            step();
            load_in = '0;
            e = (k == 10) || (k > 10 && ((k - 10) % 4 == 0));
            check("reload_tick", 32'(tick_out[0]), 32'(e));
            check("reload_clk", 32'(clk_out[0]), 32'(e));
        end
        enable_in = '0;
        step();

        // ch0 P=7, ch1 P=5; sync on the edge where ch1 would otherwise wrap.
        set_cfg(0, 8'd7, 8'd1);
        set_cfg(1, 8'd5, 8'd1);
        load_idle(2'b11);
        enable_in = 2'b11;
        for (int k = 1; k <= 4; k++) step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        check("sync_tick", 32'(tick_out), 32'h0);
        check("sync_clk", 32'(clk_out), 32'h0);
        for (int k = 1; k <= 7; k++) begin
            step();
            check("post_sync_tick", 32'(tick_out), 32'({(k == 5), (k == 7)}));
        end
        enable_in = '0;
        step();

        // ch0 P=0 H=0 stays low; ch1 P=1 H=0 ticks every cycle, clk low.
        set_cfg(0, 8'd0, 8'd0);
        set_cfg(1, 8'd1, 8'd0);
        load_idle(2'b11);
        enable_in = 2'b11;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("p0_out", 32'({clk_out[0], tick_out[0]}), 32'h0);
            check("p1_tick", 32'(tick_out[1]), 32'h1);
            check("h0_clk", 32'(clk_out[1]), 32'h0);
        end
        // ch0 P=3 H=3: output constantly high, tick every third cycle.
        set_cfg(0, 8'd3, 8'd3);
        load_in = 2'b01;
        step();
        load_in = '0;
        step();
        for (int k = 1; k <= 7; k++) begin
            step();
            check("hgep_clk", 32'(clk_out[0]), 32'h1);
            check("hgep_tick", 32'(tick_out[0]), 32'(k % 3 == 0));
        end
        // Reset mid-period with both channels running.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_clk", 32'(clk_out), 32'h0);
        check("midrst_tick", 32'(tick_out), 32'h0);
        step();
        check("postrst_clk", 32'(clk_out), 32'h0);
        check("postrst_tick", 32'(tick_out), 32'h0);
        enable_in = '0;
        step();

`ifdef MULTI_CLK_DIVIDER_PULSE_LIMIT_EN
        // ch0 P=4 H=1 L=3: three pulses, done one cycle after the third.
        set_cfg(0, 8'd4, 8'd1);
        limit_in[0 +: LS] = 16'd3;
        load_idle(2'b01);
        enable_in = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("lim_clk", 32'(clk_out[0]), 32'((k == 4) || (k == 8) || (k == 12)));
            check("lim_done", 32'(done_out[0]), 32'(k == 13));
        end
        enable_in = '0;
        step();
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_multi_clk_divider
`default_nettype wire

// File: doc/multi_clk_divider.md
MULTI_CLK_DIVIDER -- requirements
Module: multi_clk_divider

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent divider channels.
REQ-002 SHALL have parameter SIZE, default 8: width of each period/high-time field.
REQ-003 SHALL have parameter LIMIT_SIZE, default 16: width of the pulse-limit field (used only when MULTI_CLK_DIVIDER_PULSE_LIMIT_EN is defined).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk_in  input  1  sole clock; all logic on rising edge.
REQ-006 reset_in  input  1  synchronous active-high reset.
REQ-007 enable_in  input  CHANNELS  per-channel run enable.
REQ-008 max_in  input  CHANNELS*SIZE  per-channel period P, channel n at bits [n*SIZE +: SIZE].
REQ-009 high_in  input  CHANNELS*SIZE  per-channel high time H, same packing.
REQ-010 load_in  input  CHANNELS  per-channel strobe capturing max_in/high_in into the shadow registers.
REQ-011 sync_in  input  1  restart all channels in phase.
REQ-012 clk_out  output  CHANNELS  divided outputs, registered.
REQ-013 tick_out  output  CHANNELS  one-cycle pulse on the cycle each counter wraps.

Function
REQ-014 Each channel SHALL hold an active counter c (0..P-1), active P/H, and shadow P/H.
REQ-015 With enable high and P>=2: c increments each cycle and wraps P-1 -> 0; tick_out is high on the wrap cycle.
REQ-016 clk_out SHALL be registered high for exactly the cycles where c >= P-H, so with H=1 it forms a one-cycle pulse every P cycles, the first pulse on the P-th enabled edge after reset.
REQ-017 Boundary values SHALL behave as follows:
- P=0: counter stalled, clk_out=0, tick_out=0.
- P=1: tick_out every cycle.
- H=0: clk_out=0.
- H>=P: clk_out constantly 1 while enabled.
REQ-018 load_in[n] SHALL capture the shadow values; the shadow is copied to active at the next wrap, or on the next cycle if the channel is disabled.
REQ-019 A load_in on the wrap cycle SHALL take effect at that same wrap.
REQ-020 enable_in[n] low SHALL clear c to 0 and force clk_out[n]=0 and tick_out[n]=0 on the next edge; re-enable restarts from 0.
REQ-021 sync_in SHALL clear all counters to 0 and apply all pending shadows in the same cycle; no tick is generated.
REQ-022 Priority SHALL be reset_in > sync_in > enable_in low > load/count.
REQ-023 Counter arithmetic SHALL be unsigned SIZE-bit; P-H SHALL be computed without underflow (H>=P handled per REQ-017).

Reset
REQ-024 reset_in SHALL clear all counters, clk_out, tick_out and done_out to 0.
REQ-025 reset_in SHALL set active and shadow P=0 and H=0, so channels stay idle until loaded.
REQ-026 Reset mid-period SHALL discard the partial period and any pending shadow.

Configuration
REQ-027 With MULTI_CLK_DIVIDER_PULSE_LIMIT_EN defined, SHALL add:
- limit_in (input, CHANNELS*LIMIT_SIZE): pulse limit L, captured on load_in; L=0 means unlimited.
- done_out (output, CHANNELS): one-cycle done pulse.
REQ-028 With the macro defined, each rising edge of clk_out SHALL decrement the remaining count; on reaching 0 the channel stops (c held at 0, clk_out=0) and done_out pulses for one cycle; a new load_in re-arms the channel.
REQ-029 Without the macro, limit_in and done_out SHALL be absent and channels SHALL free-run.

Structure
REQ-030 Packing offsets, field-width defaults and the macro-dependent port widths SHALL live in the shared package multi_clk_divider_pkg.
REQ-031 Per-channel logic SHALL be the sub-module clk_divider_channel, instantiated CHANNELS times via generate; the top holds only packing and sync fan-out.

Verification
REQ-032 Load ch0 P=100 H=1, enable -> clk_out[0] low 99 cycles, high cycle 100, low cycle 101; repeats every 100 cycles.
REQ-033 Load ch1 P=10 H=5 -> clk_out[1] 5 low / 5 high; tick_out[1] every 10 cycles, coincident with the last high cycle.
REQ-034 Run ch0 P=10, load P=4 at c=3 -> period stays 10 until the wrap, then 4.
REQ-035 Run ch0 P=7 and ch1 P=5, pulse sync_in -> both counters 0 next cycle; first ticks 7 and 5 cycles later.
REQ-036 Load P=0, H=0, then P=3 H=3 -> clk_out stays 0, then stays 1; reset_in mid-period -> all outputs 0 on the next edge.
REQ-037 With the macro defined, load P=4 H=1 L=3 -> exactly 3 pulses, done_out high one cycle after the third pulse, then idle.
